// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Conditions two raw active-low push-buttons (UP, DOWN) for a speed selector.
//   Each key has its own independent channel: a two-flop synchronizer, a
//   saturating stability counter and a four-state debounce FSM. Each channel
//   produces a debounced level (0 = pressed) and a one-cycle press pulse.
//
//   Optional feature: define KEY_AUTOREPEAT_EN to add auto-repeat pulses while
//   a key stays PRESSED. The first repeat comes REPEAT_DELAY cycles after the
//   initial pulse, then one every REPEAT_PERIOD cycles. The default build
//   (macro undefined) gives exactly one pulse per accepted press.
//
//   Parameters (DEBOUNCE_CYCLES must be >= 2):
//     DEBOUNCE_CYCLES  stable cycles needed to accept a key change
//     REPEAT_DELAY     hold cycles from the initial pulse to the first repeat
//     REPEAT_PERIOD    cycles between later repeat pulses
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst         in   synchronous reset, active low
//     key_up_n    in   raw UP button, 0 = pressed
//     key_down_n  in   raw DOWN button, 0 = pressed
//     up          out  debounced UP level, 0 = pressed
//     down        out  debounced DOWN level, 0 = pressed
//     up_press    out  one-cycle pulse per accepted UP press (plus repeats)
//     down_press  out  one-cycle pulse per accepted DOWN press (plus repeats)
// -----------------------------------------------------------------------------

package key_conditioner_pkg;
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;
endpackage

// One key channel. state_o exposes the FSM state; the level output is decoded
// from it by the parent.
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output key_state_e state_o,
  output logic       press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // A change is accepted on the edge where the incremented count reaches
  // DEBOUNCE_CYCLES-1, i.e. when the current count is one below it.
  localparam logic [CW-1:0] CNT_PRE = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    sync_q, sync_d;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          press_q, press_d;
  logic          key_s;
  logic          enter_pressed;

  assign key_s   = sync_q[1];
  assign state_o = state_q;
  assign press_o = press_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW       = (RPT_MAXV > 2) ? $clog2(RPT_MAXV) : 1;
  localparam logic [RW-1:0] RPT_MAX  = RW'(RPT_MAXV - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  // 0: waiting for the first repeat (DELAY), 1: periodic repeats (PERIOD)
  logic          phase_q, phase_d;
  logic          rpt_fire;
`endif

  always_comb begin
    sync_d        = {sync_q[0], key_n};
    state_d       = state_q;
    cnt_d         = cnt_q;
    press_d       = 1'b0;
    enter_pressed = 1'b0;
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      RELEASED: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_PRE) begin
          state_d       = PRESSED;
          cnt_d         = cnt_inc;
          enter_pressed = 1'b1;
          press_d       = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_PRE) begin
          state_d = RELEASED;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  // Repeat counter advances only while PRESSED; RELEASE_WAIT leaves it frozen
  // so a release glitch resumes the schedule rather than restarting it.
  always_comb begin
    rpt_d    = rpt_q;
    phase_d  = phase_q;
    rpt_fire = 1'b0;
    if (enter_pressed) begin
      rpt_d   = '0;
      phase_d = 1'b0;
    end else if (state_q == PRESSED) begin
      if ((!phase_q && rpt_q == DLY_LAST) || (phase_q && rpt_q == PER_LAST)) begin
        rpt_fire = 1'b1;
        rpt_d    = '0;
        phase_d  = 1'b1;
      end else if (rpt_q != RPT_MAX) begin
        rpt_d = rpt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      phase_q <= phase_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef KEY_AUTOREPEAT_EN
      press_q <= press_d | rpt_fire;
`else
      press_q <= press_d;
`endif
    end
  end

endmodule

module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_up_n,
  input  logic key_down_n,
  output logic up,
  output logic down,
  output logic up_press,
  output logic down_press
);

  key_state_e up_state, down_state;

  key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_up_n),
    .state_o(up_state),
    .press_o(up_press)
  );

  key_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_down_n),
    .state_o(down_state),
    .press_o(down_press)
  );

  // Level reads pressed for the whole time the key is accepted as down,
  // including the release qualification window.
  assign up   = ~((up_state == PRESSED) || (up_state == RELEASE_WAIT));
  assign down = ~((down_state == PRESSED) || (down_state == RELEASE_WAIT));

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int DB  = 8;
  localparam int DLY = 20;
  localparam int PER = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic key_up_n;
  logic key_down_n;
  logic up, down, up_press, down_press;

  always #5 clk = ~clk;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_up_n  (key_up_n),
    .key_down_n(key_down_n),
    .up        (up),
    .down      (down),
    .up_press  (up_press),
    .down_press(down_press)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_off;
  int up_low, up_high, dn_low, dn_high;
  logic [31:0] up_q[$];
  logic [31:0] dn_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a new observation window: offsets count negedges after the drive.
  task automatic open_window();
    cyc_off = 0;
    up_low = 0; up_high = 0; dn_low = 0; dn_high = 0;
    up_q.delete();
    dn_q.delete();
  endtask

  // Advance n cycles, sampling outputs on each falling edge.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc_off++;
      if (up_press === 1'b1)   up_q.push_back(cyc_off);
      if (down_press === 1'b1) dn_q.push_back(cyc_off);
      if (up === 1'b0) up_low++; else up_high++;
      if (down === 1'b0) dn_low++; else dn_high++;
    end
  endtask

  // Expected pulse offsets for a clean press held for `hold` sampled cycles.
  task automatic model_press(input int hold);
    exp_q.delete();
    if (hold >= DB + 2) exp_q.push_back(DB + 2);
`ifdef KEY_AUTOREPEAT_EN
    for (int t = DB + 2 + DLY; t <= hold; t += PER) exp_q.push_back(t);
`endif
  endtask

  task automatic compare_pulses(input string name, input logic [31:0] got[$]);
    check({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_at%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic settle();
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    run(14);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic rst;
    logic up_n;
    logic dn_n;
    int   cycles;
    logic exp_up;
    logic exp_dn;
    int   exp_up_p;
    int   exp_dn_p;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst = 1'b0;
    key_up_n = 1'b1;
    key_down_n = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 1'b1,  4, 1'b1, 1'b1, 0, 0};  // reset state
    vecs[1] = '{1'b1, 1'b1, 1'b1, 12, 1'b1, 1'b1, 0, 0};  // idle
    vecs[2] = '{1'b1, 1'b0, 1'b1, 12, 1'b0, 1'b1, 1, 0};  // UP press
    vecs[3] = '{1'b1, 1'b0, 1'b0, 12, 1'b0, 1'b0, 0, 1};  // DOWN joins
    vecs[4] = '{1'b1, 1'b1, 1'b0, 12, 1'b1, 1'b0, 0, 0};  // UP release, no pulse
    vecs[5] = '{1'b1, 1'b1, 1'b1, 12, 1'b1, 1'b1, 0, 0};  // DOWN release
    vecs[6] = '{1'b1, 1'b1, 1'b0,  8, 1'b1, 1'b1, 0, 0};  // DOWN in qualification
    vecs[7] = '{1'b0, 1'b1, 1'b0,  2, 1'b1, 1'b1, 0, 0};  // reset aborts it
    vecs[8] = '{1'b1, 1'b1, 1'b0, 12, 1'b1, 1'b0, 0, 1};  // full requalification
    vecs[9] = '{1'b1, 1'b1, 1'b1, 12, 1'b1, 1'b1, 0, 0};  // release

    @(negedge clk);
    for (int v = 0; v < 10; v++) begin
      rst = vecs[v].rst;
      key_up_n = vecs[v].up_n;
      key_down_n = vecs[v].dn_n;
      open_window();
      run(vecs[v].cycles);
      check($sformatf("vec%0d_up", v), up, vecs[v].exp_up);
      check($sformatf("vec%0d_down", v), down, vecs[v].exp_dn);
      check($sformatf("vec%0d_up_pulses", v), up_q.size(), vecs[v].exp_up_p);
      check($sformatf("vec%0d_down_pulses", v), dn_q.size(), vecs[v].exp_dn_p);
    end
    settle();

    // Clean press held 40 cycles: level timing and pulse schedule.
    open_window();
    key_up_n = 1'b0;
    run(DB + 1);
    check("clean_up_before", up, 1'b1);
    run(1);
    check("clean_up_after", up, 1'b0);
    run(40 - (DB + 2));
    model_press(40);
    compare_pulses("clean_up", up_q);
    check("clean_down_pulses", dn_q.size(), 0);
    check("clean_down_low", dn_low, 0);
    settle();

    // Bounce: toggle every 3 cycles for 30 cycles, then rest high.
    open_window();
    for (int k = 0; k < 10; k++) begin
      key_up_n = (k % 2 == 0) ? 1'b0 : 1'b1;
      run(3);
    end
    key_up_n = 1'b1;
    run(15);
    check("bounce_pulses", up_q.size(), 0);
    check("bounce_up_low", up_low, 0);
    settle();

    // Release glitch: 4-cycle high glitch while held.
    open_window();
    key_up_n = 1'b0;
    run(12);
    up_high = 0;
    key_up_n = 1'b1;
    run(4);
    key_up_n = 1'b0;
    run(8);
    check("glitch_up_high", up_high, 0);
    model_press(12);
    compare_pulses("glitch", up_q);
    settle();

    // Simultaneous press: both pulses on the same cycle.
    open_window();
    key_up_n = 1'b0;
    key_down_n = 1'b0;
    run(12);
    model_press(12);
    compare_pulses("simul_up", up_q);
    compare_pulses("simul_down", dn_q);
    settle();

    // Reset mid-press at cycle 5 of qualification, key still held.
    open_window();
    key_up_n = 1'b0;
    run(7);
    rst = 1'b0;
    run(2);
    check("rst_up_level", up, 1'b1);
    check("rst_up_press", up_press, 1'b0);
    check("rst_no_early_pulse", up_q.size(), 0);
    rst = 1'b1;
    open_window();
    run(14);
    model_press(14);
    compare_pulses("rst_requal", up_q);
    settle();

    // Long hold: auto-repeat schedule (single pulse when disabled).
    open_window();
    key_up_n = 1'b0;
    run(60);
    model_press(60);
    compare_pulses("hold60", up_q);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable clk cycles needed to accept a key change (20 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the clk cycles a key must be held before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, is the clk cycles between later auto-repeat pulses.
REQ-004 Port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port key_up_n, input, 1 bit: raw asynchronous UP push-button; 0 = pressed.
REQ-007 Port key_down_n, input, 1 bit: raw asynchronous DOWN push-button; 0 = pressed.
REQ-008 Port up, output, 1 bit: debounced UP level; 0 = pressed; drives the speed selector's up input directly.
REQ-009 Port down, output, 1 bit: debounced DOWN level; 0 = pressed; drives the speed selector's down input directly.
REQ-010 Port up_press, output, 1 bit: one-clk-wide active-high pulse per accepted UP press, plus auto-repeat pulses.
REQ-011 Port down_press, output, 1 bit: one-clk-wide active-high pulse per accepted DOWN press, plus auto-repeat pulses.

Function
REQ-012 Each raw key shall pass through a two-flop synchronizer before any other logic sees it.
REQ-013 Each key shall have its own independent channel: synchronizer, stability counter, and four-state FSM (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT).
REQ-014 RELEASED: synchronized key = 0 moves the channel to PRESS_WAIT and clears its counter.
REQ-015 PRESS_WAIT: the counter increments while the key stays 0; reaching DEBOUNCE_CYCLES-1 moves to PRESSED; the key returning to 1 first moves back to RELEASED (bounce rejected).
REQ-016 PRESSED: synchronized key = 1 moves to RELEASE_WAIT and clears the counter.
REQ-017 RELEASE_WAIT: the counter increments while the key stays 1; reaching DEBOUNCE_CYCLES-1 moves to RELEASED; the key returning to 0 first moves back to PRESSED.
REQ-018 Level output (up/down) shall be 0 exactly while the channel is in PRESSED or RELEASE_WAIT, and 1 otherwise.
REQ-019 The press pulse shall assert for exactly the one cycle after the PRESS_WAIT->PRESSED transition; total latency from a clean raw edge to the pulse is 2 + DEBOUNCE_CYCLES clk cycles.
REQ-020 Counters shall be sized to the largest count they hold and shall saturate, never wrap.
REQ-021 Both keys pressed at once shall be handled fully independently; both pulses may assert in the same cycle, with no priority or masking.
REQ-022 Release shall never produce a pulse.

Reset
REQ-023 When rst = 0 at a clk edge: both FSMs go to RELEASED, counters and synchronizer flops are cleared (synchronizer flops to 1), up = down = 1, and up_press = down_press = 0.
REQ-024 Reset asserted mid-press shall abort the press; after rst returns to 1, a still-held key needs a full new DEBOUNCE_CYCLES qualification before it produces a pulse.

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN defined: a repeat counter runs in PRESSED; the first extra pulse comes REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_PERIOD cycles until the channel leaves PRESSED; entering RELEASE_WAIT freezes the repeat counter, and returning to PRESSED resumes it.
REQ-026 Macro KEY_AUTOREPEAT_EN undefined: no repeat logic is built, and exactly one pulse is produced per accepted press regardless of hold time.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-027 Clean press: key_up_n goes 1->0 and is held 40 cycles -> up = 0 and up_press pulses once, 10 cycles after the edge; down and down_press are unchanged.
REQ-028 Bounce: key_up_n toggles every 3 cycles for 30 cycles and then rests at 1 -> no pulse, and up stays 1 throughout.
REQ-029 Release glitch: with the key held, a 4-cycle high glitch on key_up_n -> up stays 0 and no new pulse occurs.
REQ-030 Simultaneous press: both keys fall on the same cycle -> up_press and down_press pulse on the same cycle.
REQ-031 Reset mid-press: rst = 0 for 2 cycles at cycle 5 of PRESS_WAIT with the key still held -> pulse occurs 8+2 cycles after rst rises, and outputs are 1/0 during reset.
REQ-032 Auto-repeat (macro defined, key held 60 cycles) -> pulses at +10, +30, +35, +40, ... cycles; with the macro undefined -> only the pulse at +10.
